sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Parametrised successor to the raster plotter: walks a runtime-sized sprite, issues sprite-RAM addresses and compensates for RAM read latency.
- Emits screen-space pixels at origin + offset, with optional colour-key transparency and screen clipping.
- Start/busy/done handshake; sits between game logic and the VGA adapter's plot port.

Parameters:
- WIDTH_X, 8, screen x coordinate width
- WIDTH_Y, 7, screen y coordinate width
- SPR_WX, 5, sprite-local x width (max sprite width 2^SPR_WX)
- SPR_WY, 5, sprite-local y width
- SCREEN_X, 160, visible columns; x >= SCREEN_X is clipped
- SCREEN_Y, 120, visible rows
- COLOR_W, 3, colour bits
- RAM_LATENCY, 1, cycles from address register to valid rom_color (1..4)
- KEY_COLOR, 0, transparent colour value

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin blit; sampled only in IDLE
- origin_x  in  WIDTH_X  screen x of sprite top-left
- origin_y  in  WIDTH_Y  screen y of sprite top-left
- size_w  in  SPR_WX+1  sprite width in pixels
- size_h  in  SPR_WY+1  sprite height in pixels
- key_en  in  1  enable transparency
- spr_x  out  SPR_WX  sprite RAM x address (registered)
- spr_y  out  SPR_WY  sprite RAM y address (registered)
- rom_color  in  COLOR_W  sprite RAM data
- vga_x  out  WIDTH_X  plot x
- vga_y  out  WIDTH_Y  plot y
- vga_color  out  COLOR_W  plot colour
- vga_plot  out  1  write strobe, one cycle per emitted pixel
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; spr_x, spr_y, vga_x, vga_y, vga_color = 0; vga_plot, busy, done = 0; pipeline valid bits cleared.
- IDLE:
  - start=1 latches origin_x/y, size_w/h and key_en, then goes to SCAN (busy=1 next cycle).
  - If size_w=0 or size_h=0: go to DONE directly; no plots.
- SCAN:
  - One address per cycle, row-major: spr_x increments to size_w-1, then wraps to 0 and spr_y increments.
  - After issuing (size_w-1, size_h-1), go to FLUSH.
- Pipeline: a valid bit plus screen coordinates are delayed RAM_LATENCY stages alongside each address.
  - When the aligned stage is valid, the output register loads vga_x/vga_y/vga_color from that stage and rom_color.
  - vga_plot is set from the same stage, subject to suppression below.
- Coordinates: screen x = origin_x + spr_x, computed at WIDTH_X+1 bits with no wrap; y likewise.
- Suppression: vga_plot=0 if key_en and rom_color==KEY_COLOR, or sum_x >= SCREEN_X, or sum_y >= SCREEN_Y. Other vga_* outputs may still update.
- FLUSH: waits until all pipeline valid bits are clear, then goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- start while busy: ignored; latched parameters are unchanged.
- Timing, with start accepted at edge t0:
  - First address presented in cycle t0+1.
  - First vga_plot at cycle t0+RAM_LATENCY+2.
  - Last plot at t0+W*H+RAM_LATENCY+1.
  - done at t0+W*H+RAM_LATENCY+2.
- reset mid-blit: returns to IDLE on the next edge; no further vga_plot; done is not pulsed.
- Latched inputs are not re-read during a blit.

Decomposition:
- Shared package: colour width, KEY_COLOR, SCREEN_X/SCREEN_Y defaults, state encoding (IDLE, SCAN, FLUSH, DONE).
- One sub-module, blit_delay_line: parametrised RAM_LATENCY-deep shift register carrying {valid, sx, sy, clip}.
- Scan counters and FSM stay in the top module.

Test Plan:
- 4x3 sprite, origin (10,5), L=1, key_en=0, RAM returns x+y*4: exactly 12 plots.
  - First at cycle 3: (10,5), colour 0. Last at cycle 14: (13,7).
  - done pulses at cycle 15; busy high cycles 1-14.
- Clip: origin (158,118), 4x4: only (158,118), (159,118), (158,119), (159,119) plotted.
  - done timing is unchanged (cycle 19 at L=1).
- Transparency: key_en=1, KEY_COLOR=0, pixels alternating 0/5: only the colour-5 pixels strobe.
  - With key_en=0, all pixels strobe.
- Latency sweep L=1..4, 2x2 sprite: vga_color matches the RAM word for each coordinate.
  - done at cycle 4+L+2.
- Handshake: start re-asserted mid-blit with a new origin is ignored (plots still use the old origin).
  - size_w=0 yields no plots and done at cycle 1.
- Reset asserted at cycle 5 of a 4x3 blit: vga_plot=0 from cycle 6 onward, no done pulse, state IDLE.
  - A new start then completes normally.

Source files
------------

// File: rtl/sprite_blitter_pkg.sv
// rtl/sprite_blitter_pkg.sv - shared constants and state encoding for the sprite blitter
package sprite_blitter_pkg;

  localparam int COLOR_W_DEF   = 3;
  localparam int KEY_COLOR_DEF = 0;
  localparam int SCREEN_X_DEF  = 160;
  localparam int SCREEN_Y_DEF  = 120;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter_delay_line.sv
// rtl/sprite_blitter_delay_line.sv - RAM-latency-matched shift register for pixel side data
module blit_delay_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          any_valid
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][DW-1:0] dat_q, dat_d;

  // advance every stage by one position each cycle
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = in_valid;
    dat_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // stage registers; only the valid bits matter after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite walker with RAM latency compensation, clipping and colour key
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int WIDTH_X     = 8,
  parameter int WIDTH_Y     = 7,
  parameter int SPR_WX      = 5,
  parameter int SPR_WY      = 5,
  parameter int SCREEN_X    = SCREEN_X_DEF,
  parameter int SCREEN_Y    = SCREEN_Y_DEF,
  parameter int COLOR_W     = COLOR_W_DEF,
  parameter int RAM_LATENCY = 1,
  parameter int KEY_COLOR   = KEY_COLOR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_X-1:0] origin_x,
  input  logic [WIDTH_Y-1:0] origin_y,
  input  logic [SPR_WX:0]    size_w,
  input  logic [SPR_WY:0]    size_h,
  input  logic               key_en,
  output logic [SPR_WX-1:0]  spr_x,
  output logic [SPR_WY-1:0]  spr_y,
  input  logic [COLOR_W-1:0] rom_color,
  output logic [WIDTH_X-1:0] vga_x,
  output logic [WIDTH_Y-1:0] vga_y,
  output logic [COLOR_W-1:0] vga_color,
  output logic               vga_plot,
  output logic               busy,
  output logic               done
);

  localparam int DW = WIDTH_X + WIDTH_Y + 1;

  blit_state_e state_q, state_d;

  logic [WIDTH_X-1:0] org_x_q, org_x_d;
  logic [WIDTH_Y-1:0] org_y_q, org_y_d;
  logic [SPR_WX:0]    size_w_q, size_w_d;
  logic [SPR_WY:0]    size_h_q, size_h_d;
  logic               key_en_q, key_en_d;
  logic [SPR_WX-1:0]  spr_x_q, spr_x_d;
  logic [SPR_WY-1:0]  spr_y_q, spr_y_d;

  logic [WIDTH_X-1:0] vga_x_q, vga_x_d;
  logic [WIDTH_Y-1:0] vga_y_q, vga_y_d;
  logic [COLOR_W-1:0] vga_color_q, vga_color_d;
  logic               vga_plot_q, vga_plot_d;

  logic [WIDTH_X:0]   sum_x;
  logic [WIDTH_Y:0]   sum_y;
  logic               clip_s;
  logic               last_x, last_y;
  logic               issue;

  logic               dl_valid, dl_any, dl_clip;
  logic [DW-1:0]      dl_data;
  logic [WIDTH_X-1:0] dl_x;
  logic [WIDTH_Y-1:0] dl_y;
  logic               transparent;

  // screen position is formed one bit wider so an off-screen sum never wraps back on-screen
  assign sum_x  = {1'b0, org_x_q} + (WIDTH_X+1)'(spr_x_q);
  assign sum_y  = {1'b0, org_y_q} + (WIDTH_Y+1)'(spr_y_q);
  assign clip_s = (sum_x >= (WIDTH_X+1)'(SCREEN_X)) || (sum_y >= (WIDTH_Y+1)'(SCREEN_Y));

  assign last_x = ({1'b0, spr_x_q} == size_w_q - (SPR_WX+1)'(1));
  assign last_y = ({1'b0, spr_y_q} == size_h_q - (SPR_WY+1)'(1));
  assign issue  = (state_q == ST_SCAN);

  blit_delay_line #(
    .DEPTH (RAM_LATENCY),
    .DW    (DW)
  ) u_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (issue),
    .in_data   ({sum_x[WIDTH_X-1:0], sum_y[WIDTH_Y-1:0], clip_s}),
    .out_valid (dl_valid),
    .out_data  (dl_data),
    .any_valid (dl_any)
  );

  assign {dl_x, dl_y, dl_clip} = dl_data;
  assign transparent = key_en_q && (rom_color == COLOR_W'(KEY_COLOR));

  // control FSM: latch the job, walk the sprite row-major, drain the pipeline, pulse done
  always_comb begin
    state_d  = state_q;
    org_x_d  = org_x_q;
    org_y_d  = org_y_q;
    size_w_d = size_w_q;
    size_h_d = size_h_q;
    key_en_d = key_en_q;
    spr_x_d  = spr_x_q;
    spr_y_d  = spr_y_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          org_x_d  = origin_x;
          org_y_d  = origin_y;
          size_w_d = size_w;
          size_h_d = size_h;
          key_en_d = key_en;
          spr_x_d  = '0;
          spr_y_d  = '0;
          state_d  = (size_w == '0 || size_h == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!last_x) begin
          spr_x_d = spr_x_q + SPR_WX'(1);
        end else if (!last_y) begin
          spr_x_d = '0;
          spr_y_d = spr_y_q + SPR_WY'(1);
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!dl_any) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // plot register: loads whenever the stage aligned with rom_color carries a pixel
  always_comb begin
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    vga_plot_d  = 1'b0;
    if (dl_valid) begin
      vga_x_d     = dl_x;
      vga_y_d     = dl_y;
      vga_color_d = rom_color;
      vga_plot_d  = !dl_clip && !transparent;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      org_x_q     <= '0;
      org_y_q     <= '0;
      size_w_q    <= '0;
      size_h_q    <= '0;
      key_en_q    <= 1'b0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      vga_plot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      org_x_q     <= org_x_d;
      org_y_q     <= org_y_d;
      size_w_q    <= size_w_d;
      size_h_q    <= size_h_d;
      key_en_q    <= key_en_d;
      spr_x_q     <= spr_x_d;
      spr_y_q     <= spr_y_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_plot_q  <= vga_plot_d;
    end
  end

  assign spr_x     = spr_x_q;
  assign spr_y     = spr_y_q;
  assign vga_x     = vga_x_q;
  assign vga_y     = vga_y_q;
  assign vga_color = vga_color_q;
  assign vga_plot  = vga_plot_q;
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - self-checking bench for sprite_blitter at RAM latencies 1..4
module tb_sprite_blitter;

  localparam int NI = 4;
  localparam int SX = 160;
  localparam int SY = 120;

  typedef struct {
    int ox;
    int oy;
    int w;
    int h;
    int key;
    int pat;
    int exp_plots;
    int exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] origin_x;
  logic [6:0] origin_y;
  logic [5:0] size_w;
  logic [5:0] size_h;
  logic       key_en;

  logic [4:0] spr_x_w [NI];
  logic [4:0] spr_y_w [NI];
  logic [2:0] rom_w   [NI];
  logic [7:0] vx_w    [NI];
  logic [6:0] vy_w    [NI];
  logic [2:0] vc_w    [NI];
  logic       plot_w  [NI];
  logic       busy_w  [NI];
  logic       done_w  [NI];

  int n_vec = 0;
  int n_err = 0;

  int cur_ox, cur_oy, cur_w, cur_h, cur_key, cur_pat;
  logic [2:0] rmem [32][32];

  always #5 clk = ~clk;

  function automatic logic [2:0] ram_word(input int px, input int py);
    case (cur_pat)
      0:       return 3'((px + py * 4) & 7);
      1:       return (((py * cur_w + px) % 2) != 0) ? 3'd5 : 3'd0;
      default: return rmem[py][px];
    endcase
  endfunction

  // pixel k of the current job in row-major order; returns whether it should strobe
  function automatic bit pix_at(input int k, output int x, output int y, output int c);
    int px, py;
    px = k % cur_w;
    py = k / cur_w;
    x  = cur_ox + px;
    y  = cur_oy + py;
    c  = int'(ram_word(px, py));
    return (x < SX) && (y < SY) && !(cur_key != 0 && c == 0);
  endfunction

  function automatic int count_plots();
    int x, y, c, cnt;
    cnt = 0;
    for (int k = 0; k < cur_w * cur_h; k++) cnt += int'(pix_at(k, x, y, c));
    return cnt;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_lat
    logic [2:0] pipe [gi+1];

    always @(posedge clk) begin
      pipe[0] <= ram_word(int'(spr_x_w[gi]), int'(spr_y_w[gi]));
      for (int j = 1; j <= gi; j++) pipe[j] <= pipe[j-1];
    end
    assign rom_w[gi] = pipe[gi];

    sprite_blitter #(
      .RAM_LATENCY (gi + 1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .origin_x  (origin_x),
      .origin_y  (origin_y),
      .size_w    (size_w),
      .size_h    (size_h),
      .key_en    (key_en),
      .spr_x     (spr_x_w[gi]),
      .spr_y     (spr_y_w[gi]),
      .rom_color (rom_w[gi]),
      .vga_x     (vx_w[gi]),
      .vga_y     (vy_w[gi]),
      .vga_color (vc_w[gi]),
      .vga_plot  (plot_w[gi]),
      .busy      (busy_w[gi]),
      .done      (done_w[gi])
    );
  end

  task automatic check(input string nm, input int l, input int n, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s L=%0d cycle=%0d got=%0d expected=%0d", nm, l, n, got, exp);
    end
  endtask

  // one blit; inj_n re-asserts start with a different job in that cycle, rst_n pulses reset
  task automatic run_blit(input vec_t v, input int inj_n, input int rst_n);
    int total, nmax, plots0, done0;
    bit zero;
    @(negedge clk);
    origin_x = 8'(v.ox);
    origin_y = 7'(v.oy);
    size_w   = 6'(v.w);
    size_h   = 6'(v.h);
    key_en   = v.key[0];
    start    = 1'b1;
    cur_ox = v.ox; cur_oy = v.oy; cur_w = v.w; cur_h = v.h; cur_key = v.key; cur_pat = v.pat;
    @(posedge clk);
    #1;
    start    = 1'b0;
    origin_x = 8'($urandom);
    origin_y = 7'($urandom);
    size_w   = 6'($urandom);
    size_h   = 6'($urandom);
    key_en   = 1'($urandom);
    zero   = (v.w == 0) || (v.h == 0);
    total  = v.w * v.h;
    nmax   = zero ? 4 : total + NI + 5;
    plots0 = 0;
    done0  = 0;
    for (int n = 1; n <= nmax; n++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        int l, k, ex, ey, ec;
        bit ep, eb, ed;
        l  = i + 1;
        ep = 1'b0;
        ex = 0; ey = 0; ec = 0;
        if (rst_n != 0 && n > rst_n) begin
          eb = 1'b0;
          ed = 1'b0;
        end else begin
          eb = !zero && (n <= total + l + 1);
          ed = zero ? (n == 1) : (n == total + l + 2);
          k  = n - l - 2;
          if (!zero && k >= 0 && k < total) ep = pix_at(k, ex, ey, ec);
        end
        check("busy", l, n, int'(busy_w[i]), int'(eb));
        check("done", l, n, int'(done_w[i]), int'(ed));
        check("plot", l, n, int'(plot_w[i]), int'(ep));
        if (ep) begin
          check("vga_x", l, n, int'(vx_w[i]), ex);
          check("vga_y", l, n, int'(vy_w[i]), ey);
          check("vga_color", l, n, int'(vc_w[i]), ec);
        end
        if (i == 0) begin
          plots0 += int'(plot_w[0]);
          if (done_w[0] && done0 == 0) done0 = n;
        end
      end
      if (inj_n != 0 && n == inj_n) begin
        start    = 1'b1;
        origin_x = 8'd50;
        origin_y = 7'd50;
        size_w   = 6'd2;
        size_h   = 6'd2;
      end else begin
        start = 1'b0;
      end
      reset = (rst_n != 0 && n == rst_n);
    end
    if (rst_n == 0) begin
      check("plot_count", 1, 0, plots0, v.exp_plots);
      check("done_cycle", 1, 0, done0, v.exp_done);
    end else begin
      check("plots_after_reset_only_early", 1, 0, int'(plots0 <= rst_n), 1);
    end
  endtask

  vec_t tbl [11];
  vec_t rv;

  initial begin
    tbl[0]  = '{ox: 10,  oy: 5,   w: 4,  h: 3, key: 0, pat: 0, exp_plots: 12, exp_done: 15};
    tbl[1]  = '{ox: 158, oy: 118, w: 4,  h: 4, key: 0, pat: 2, exp_plots: 4,  exp_done: 19};
    tbl[2]  = '{ox: 10,  oy: 5,   w: 4,  h: 3, key: 1, pat: 1, exp_plots: 6,  exp_done: 15};
    tbl[3]  = '{ox: 10,  oy: 5,   w: 4,  h: 3, key: 0, pat: 1, exp_plots: 12, exp_done: 15};
    tbl[4]  = '{ox: 20,  oy: 30,  w: 2,  h: 2, key: 0, pat: 2, exp_plots: 4,  exp_done: 7};
    tbl[5]  = '{ox: 10,  oy: 10,  w: 0,  h: 3, key: 0, pat: 0, exp_plots: 0,  exp_done: 1};
    tbl[6]  = '{ox: 10,  oy: 10,  w: 3,  h: 0, key: 0, pat: 0, exp_plots: 0,  exp_done: 1};
    tbl[7]  = '{ox: 159, oy: 119, w: 1,  h: 1, key: 0, pat: 2, exp_plots: 1,  exp_done: 4};
    tbl[8]  = '{ox: 255, oy: 127, w: 2,  h: 2, key: 0, pat: 2, exp_plots: 0,  exp_done: 7};
    tbl[9]  = '{ox: 0,   oy: 0,   w: 32, h: 1, key: 0, pat: 0, exp_plots: 32, exp_done: 35};
    tbl[10] = '{ox: 100, oy: 100, w: 5,  h: 4, key: 1, pat: 0, exp_plots: 16, exp_done: 23};

    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) rmem[r][c] = 3'($urandom);
    cur_ox = 0; cur_oy = 0; cur_w = 1; cur_h = 1; cur_key = 0; cur_pat = 0;
    reset = 1'b1; start = 1'b0; origin_x = '0; origin_y = '0;
    size_w = '0; size_h = '0; key_en = 1'b0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_spr_x", i + 1, 0, int'(spr_x_w[i]), 0);
      check("rst_spr_y", i + 1, 0, int'(spr_y_w[i]), 0);
      check("rst_vga_x", i + 1, 0, int'(vx_w[i]), 0);
      check("rst_vga_y", i + 1, 0, int'(vy_w[i]), 0);
      check("rst_vga_color", i + 1, 0, int'(vc_w[i]), 0);
      check("rst_plot", i + 1, 0, int'(plot_w[i]), 0);
      check("rst_busy", i + 1, 0, int'(busy_w[i]), 0);
      check("rst_done", i + 1, 0, int'(done_w[i]), 0);
    end
    reset = 1'b0;

    for (int t = 0; t < 11; t++) run_blit(tbl[t], 0, 0);

    run_blit(tbl[0], 4, 0);
    run_blit(tbl[0], 15, 0);
    run_blit(tbl[5], 1, 0);
    run_blit(tbl[0], 0, 5);
    run_blit(tbl[0], 0, 0);

    for (int t = 0; t < 16; t++) begin
      rv.ox  = ($urandom_range(0, 1) != 0) ? $urandom_range(150, 175) : $urandom_range(0, 255);
      rv.oy  = ($urandom_range(0, 1) != 0) ? $urandom_range(112, 127) : $urandom_range(0, 127);
      rv.w   = $urandom_range(0, 7);
      rv.h   = $urandom_range(0, 7);
      rv.key = $urandom_range(0, 1);
      rv.pat = $urandom_range(0, 2);
      cur_ox = rv.ox; cur_oy = rv.oy; cur_w = rv.w; cur_h = rv.h; cur_key = rv.key; cur_pat = rv.pat;
      rv.exp_plots = count_plots();
      rv.exp_done  = (rv.w == 0 || rv.h == 0) ? 1 : rv.w * rv.h + 3;
      run_blit(rv, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
